vga_fb_scanout_arbiter: RTL



---
 rtl/vga_fb_scanout_arbiter_if.sv | 28 ++
 rtl/vga_fb_scanout_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/vga_fb_scanout_arbiter_if.sv
// Host-write and framebuffer-RAM bus shared by the scanout arbiter and its surroundings.
//   wr_valid_i/wr_ready_o/wr_addr_i/wr_data_i : host pixel write, valid/ready handshake
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o  : single-port RAM access strobe and write data
//   mem_rdata_i                               : RAM read data, one cycle after a read strobe
// slave  = the arbiter; master = host writer plus RAM.
interface vga_fb_scanout_arbiter_if #(
  parameter int ADDR_W = 19
);
  logic              wr_valid_i;
  logic              wr_ready_o;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [2:0]        wr_data_i;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [2:0]        mem_wdata_o;
  logic [2:0]        mem_rdata_i;

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, mem_rdata_i,
    output wr_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, mem_rdata_i,
    input  wr_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/vga_fb_scanout_arbiter.sv
// Shares one single-port pixel framebuffer between display scanout (read, priority)
// and a host writer. Scanout prefetches pixels into a small FIFO from which the VGA
// timing chain pulls one 3-bit {r,g,b} pixel per pix_req_i pulse.
// Ports:
//   clk_i, rst_i   : system clock, synchronous active-high reset
//   frame_start_i  : 1-cycle pulse, restart scanout at address 0 and flush the FIFO
//   pix_req_i      : 1-cycle pulse, consume one pixel (at most one per 2 cycles)
//   pix_o          : registered pixel for the latest request, held between requests
//   underrun_o     : sticky flag, a request found the FIFO empty
//   bus            : host write handshake and RAM access (see the interface file)
module vga_fb_scanout_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int DEPTH    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_start_i,
  input  logic       pix_req_i,
  output logic [2:0] pix_o,
  output logic       underrun_o,
  vga_fb_scanout_arbiter_if.slave bus
);
  localparam int NPIX  = H_ACTIVE * V_ACTIVE;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [CNT_W:0]    DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] rd_addr_reg;
  logic [2:0]        fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              inflight_reg;
  // Number of future read returns to throw away, one per starved request.
  logic [ADDR_W-1:0] drop_reg;
  logic [2:0]        pix_reg;
  logic              underrun_reg;

  logic [CNT_W:0] occupancy;
  logic           scan_grant;
  logic           wr_ready;
  logic           host_xfer;
  logic           wr_in_range;
  logic           fifo_empty;
  logic           pop;
  logic           starve;
  logic           ret_push;
  logic           ret_drop;

  always_comb begin
    // A read in flight already owns a FIFO slot, so the FIFO can never overflow.
    occupancy   = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
    scan_grant  = !rst_i && !frame_start_i && (occupancy < DEPTH_OCC);
    // Ready depends only on the scan decision, never on wr_valid_i.
    wr_ready    = !rst_i && !scan_grant;
    host_xfer   = wr_ready && bus.wr_valid_i;
    wr_in_range = bus.wr_addr_i <= LAST_ADDR;
    fifo_empty  = (count_reg == '0);
    // The pop decision sees the count before this cycle's push.
    pop         = pix_req_i && !frame_start_i && !fifo_empty;
    starve      = pix_req_i && !frame_start_i && fifo_empty;
    // A return arriving on a frame_start cycle belongs to the old frame: never pushed.
    ret_push    = inflight_reg && !frame_start_i && (drop_reg == '0);
    ret_drop    = inflight_reg && !frame_start_i && (drop_reg != '0);
  end

  assign bus.wr_ready_o  = wr_ready;
  // Out-of-range host writes are accepted but never reach the RAM.
  assign bus.mem_en_o    = scan_grant || (host_xfer && wr_in_range);
  assign bus.mem_we_o    = !scan_grant && host_xfer && wr_in_range;
  assign bus.mem_addr_o  = scan_grant ? rd_addr_reg : bus.wr_addr_i;
  assign bus.mem_wdata_o = bus.wr_data_i;
  assign pix_o           = pix_reg;
  assign underrun_o      = underrun_reg;

  always_ff @(posedge clk_i) begin
    if (ret_push && !rst_i) begin
      fifo_mem[wr_ptr_reg] <= bus.mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_addr_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= 1'b0;
      drop_reg     <= '0;
      pix_reg      <= 3'd0;
      underrun_reg <= 1'b0;
    end else begin
      if (frame_start_i) begin
        rd_addr_reg <= '0;
        wr_ptr_reg  <= '0;
        rd_ptr_reg  <= '0;
        count_reg   <= '0;
        drop_reg    <= '0;
        pix_reg     <= 3'd0;
      end else begin
        if (scan_grant) begin
          rd_addr_reg <= (rd_addr_reg == LAST_ADDR) ? '0 : rd_addr_reg + 1'b1;
        end
        if (ret_push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
          pix_reg    <= fifo_mem[rd_ptr_reg];
        end
        if (starve) begin
          pix_reg      <= 3'd0;
          underrun_reg <= 1'b1;
        end
        count_reg <= count_reg + CNT_W'(ret_push) - CNT_W'(pop);
        // Starve and discard can coincide; the net change is then zero.
        drop_reg  <= drop_reg + ADDR_W'(starve) - ADDR_W'(ret_drop);
      end
      inflight_reg <= scan_grant;
    end
  end
endmodule
